// File: rtl/spi_voice_cmd_rx.sv
// rtl/spi_voice_cmd_rx.sv - SPI-slave receiver turning 7-byte MCU note frames into the SPI_* voice command bus.
// All SPI pins are oversampled in the i_clk domain; a frame is decoded once cs_n returns high.
module spi_voice_cmd_rx #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [3:0] HEADER       = 4'hA,
  parameter int         TUNING_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_sclk,
  input  logic                    i_cs_n,
  input  logic                    i_mosi,
  output logic                    o_SPI_note_status,
  output logic [7:0]              o_SPI_voice_index,
  output logic [TUNING_WIDTH-1:0] o_SPI_tuning_code,
  output logic [7:0]              o_SPI_velocity,
  output logic                    o_SPI_flag,
  output logic                    o_frame_error
);

  localparam int         FRAME_BITS = 24 + TUNING_WIDTH;
  localparam logic [5:0] FRAME_CNT  = 6'(FRAME_BITS);
  localparam logic [5:0] CNT_MAX    = 6'd63;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic                    sclk_prev_q, sclk_prev_d;
  logic                    cs_prev_q, cs_prev_d;

  logic [1:0]              state_q, state_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [5:0]              bit_cnt_q, bit_cnt_d;

  logic                    note_status_q, note_status_d;
  logic [7:0]              voice_index_q, voice_index_d;
  logic [TUNING_WIDTH-1:0] tuning_code_q, tuning_code_d;
  logic [7:0]              velocity_q, velocity_d;
  logic                    flag_q, flag_d;
  logic                    frame_error_q, frame_error_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, cs_rise, cs_fall;
  logic frame_ok;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  assign frame_ok = (bit_cnt_q == FRAME_CNT) &&
                    (shreg_q[FRAME_BITS-1 -: 4] == HEADER);

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
  end

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    note_status_d = note_status_q;
    voice_index_d = voice_index_q;
    tuning_code_d = tuning_code_q;
    velocity_d    = velocity_q;
    flag_d        = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          shreg_d   = '0;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // End of frame wins over a coincident sclk edge.
        if (cs_rise) begin
          state_d = ST_CHECK;
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], mosi_s};
          if (bit_cnt_q != CNT_MAX) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      ST_CHECK: begin
        if (frame_ok) begin
          note_status_d = shreg_q[FRAME_BITS-8];
          voice_index_d = shreg_q[FRAME_BITS-9 -: 8];
          tuning_code_d = shreg_q[TUNING_WIDTH+7:8];
          velocity_d    = shreg_q[7:0];
          flag_d        = 1'b1;
        end else begin
          frame_error_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b1;
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      note_status_q <= 1'b0;
      voice_index_q <= '0;
      tuning_code_q <= '0;
      velocity_q    <= '0;
      flag_q        <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      cs_prev_q     <= cs_prev_d;
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      note_status_q <= note_status_d;
      voice_index_q <= voice_index_d;
      tuning_code_q <= tuning_code_d;
      velocity_q    <= velocity_d;
      flag_q        <= flag_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign o_SPI_note_status = note_status_q;
  assign o_SPI_voice_index = voice_index_q;
  assign o_SPI_tuning_code = tuning_code_q;
  assign o_SPI_velocity    = velocity_q;
  assign o_SPI_flag        = flag_q;
  assign o_frame_error     = frame_error_q;

endmodule

// File: tb/tb_spi_voice_cmd_rx.sv
// tb/tb_spi_voice_cmd_rx.sv - self-checking bench for spi_voice_cmd_rx against a frame-level decode model.
module tb_spi_voice_cmd_rx;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_sclk = 1'b0;
  logic        i_cs_n = 1'b1;
  logic        i_mosi = 1'b0;
  logic        o_SPI_note_status;
  logic [7:0]  o_SPI_voice_index;
  logic [31:0] o_SPI_tuning_code;
  logic [7:0]  o_SPI_velocity;
  logic        o_SPI_flag;
  logic        o_frame_error;

  spi_voice_cmd_rx #(
    .SYNC_STAGES (2),
    .HEADER      (4'hA),
    .TUNING_WIDTH(32)
  ) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_sclk           (i_sclk),
    .i_cs_n           (i_cs_n),
    .i_mosi           (i_mosi),
    .o_SPI_note_status(o_SPI_note_status),
    .o_SPI_voice_index(o_SPI_voice_index),
    .o_SPI_tuning_code(o_SPI_tuning_code),
    .o_SPI_velocity   (o_SPI_velocity),
    .o_SPI_flag       (o_SPI_flag),
    .o_frame_error    (o_frame_error)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int flag_cnt = 0;
  int err_cnt = 0;

  logic        exp_ns = 1'b0;
  logic [7:0]  exp_voice = 8'h00;
  logic [31:0] exp_tune = 32'h0;
  logic [7:0]  exp_vel = 8'h00;

  logic [48:0] prev_fields = '0;
  logic [48:0] cur_fields;
  assign cur_fields = {o_SPI_note_status, o_SPI_voice_index, o_SPI_tuning_code, o_SPI_velocity};

  // Strobe counting plus a watch that fields only move together with a flag pulse.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      prev_fields = '0;
    end else begin
      if (o_SPI_flag) flag_cnt++;
      if (o_frame_error) err_cnt++;
      checks++;
      if (!o_SPI_flag && cur_fields !== prev_fields) begin
        errors++;
        $display("FAIL field_hold: fields=%h changed from %h without flag", cur_fields, prev_fields);
      end
      prev_fields = cur_fields;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic shift_bits(input logic [63:0] vec, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      i_mosi = vec[i];
      tick(4);
      i_sclk = 1'b1;
      tick(4);
      i_sclk = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [63:0] vec, input int n);
    i_cs_n = 1'b0;
    tick(4);
    shift_bits(vec, n);
    tick(4);
    i_cs_n = 1'b1;
    tick(12);
  endtask

  task automatic check_fields(input string name);
    checks++;
    if (o_SPI_note_status !== exp_ns) begin
      errors++;
      $display("FAIL %s note_status: got %0b want %0b", name, o_SPI_note_status, exp_ns);
    end
    checks++;
    if (o_SPI_voice_index !== exp_voice) begin
      errors++;
      $display("FAIL %s voice_index: got %0d want %0d", name, o_SPI_voice_index, exp_voice);
    end
    checks++;
    if (o_SPI_tuning_code !== exp_tune) begin
      errors++;
      $display("FAIL %s tuning_code: got %h want %h", name, o_SPI_tuning_code, exp_tune);
    end
    checks++;
    if (o_SPI_velocity !== exp_vel) begin
      errors++;
      $display("FAIL %s velocity: got %0d want %0d", name, o_SPI_velocity, exp_vel);
    end
  endtask

  // Reference: a frame is accepted only with exactly 56 bits and header nibble A.
  task automatic run_frame(input string name, input logic [63:0] vec, input int n);
    int  f0;
    int  e0;
    bit  valid;
    f0 = flag_cnt;
    e0 = err_cnt;
    valid = (n == 56) && (vec[55:52] == 4'hA);
    send_bits(vec, n);
    if (valid) begin
      exp_ns    = vec[48];
      exp_voice = vec[47:40];
      exp_tune  = vec[39:8];
      exp_vel   = vec[7:0];
    end
    checks++;
    if (flag_cnt - f0 != (valid ? 1 : 0)) begin
      errors++;
      $display("FAIL %s flag_pulses: got %0d want %0d", name, flag_cnt - f0, valid ? 1 : 0);
    end
    checks++;
    if (err_cnt - e0 != (valid ? 0 : 1)) begin
      errors++;
      $display("FAIL %s error_pulses: got %0d want %0d", name, err_cnt - e0, valid ? 0 : 1);
    end
    check_fields(name);
  endtask

  function automatic logic [63:0] mk(input logic [55:0] f);
    return {8'h00, f};
  endfunction

  task automatic test_reset;
    i_reset = 1'b0;
    tick(10);
    checks++;
    if (o_SPI_flag !== 1'b0 || o_frame_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: flag=%0b err=%0b want 0 0", o_SPI_flag, o_frame_error);
    end
    check_fields("reset_held");
    i_reset = 1'b1;
    tick(10);
    check_fields("reset_released");
    checks++;
    if (flag_cnt != 0 || err_cnt != 0) begin
      errors++;
      $display("FAIL reset_no_strobe: flags=%0d errs=%0d want 0 0", flag_cnt, err_cnt);
    end
  endtask

  task automatic test_single_frame;
    run_frame("frame_a0", mk(56'hA0FD01312D0064), 56);
    checks++;
    if (o_SPI_tuning_code !== 32'd20000000) begin
      errors++;
      $display("FAIL frame_a0_tuning_dec: got %0d want 20000000", o_SPI_tuning_code);
    end
  endtask

  task automatic test_back_to_back;
    run_frame("b2b_first", mk(56'hA1FC01312D007F), 56);
    run_frame("b2b_second", mk(56'hA0FC0000000000), 56);
  endtask

  task automatic test_bad_header;
    run_frame("bad_header", mk(56'hB1FC01312D007F), 56);
  endtask

  task automatic test_bad_length;
    logic [55:0] f;
    f = 56'hA1FC01312D007F;
    run_frame("short_55", 64'(f >> 1), 55);
    run_frame("long_57", {7'h00, f, 1'b1}, 57);
    run_frame("zero_len", 64'h0, 0);
    run_frame("long_64", {f, 8'h5A}, 64);
  endtask

  task automatic test_reset_midframe;
    int f0;
    int e0;
    f0 = flag_cnt;
    e0 = err_cnt;
    i_cs_n = 1'b0;
    tick(4);
    shift_bits(mk(56'hA1101234567842) >> 26, 30);
    i_reset = 1'b0;
    tick(3);
    i_cs_n = 1'b1;
    i_sclk = 1'b0;
    tick(5);
    exp_ns = 1'b0;
    exp_voice = 8'h00;
    exp_tune = 32'h0;
    exp_vel = 8'h00;
    check_fields("midframe_reset");
    i_reset = 1'b1;
    tick(15);
    checks++;
    if (flag_cnt != f0 || err_cnt != e0) begin
      errors++;
      $display("FAIL midframe_no_strobe: flags+%0d errs+%0d want 0 0", flag_cnt - f0, err_cnt - e0);
    end
    run_frame("after_reset", mk(56'hA1101234567842), 56);
  endtask

  task automatic test_random;
    logic [63:0] vec;
    int          n;
    for (int i = 0; i < 12; i++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 64)) : 56;
      vec = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) vec[55:52] = 4'hA;
      run_frame($sformatf("random_%0d", i), vec, n);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bad_header();
    test_bad_length();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_voice_cmd_rx.md
Name: spi_voice_cmd_rx

Overview:
- SPI-slave command receiver sitting between the external MIDI/control MCU and voice_controller.
- Deserialises fixed 7-byte note commands from the MCU and presents them as the parallel SPI_* command bus that voice_controller consumes: note_status, voice_index, tuning_code, velocity and a one-cycle flag.
- Runs entirely in the i_clk domain; the SPI pins are oversampled through synchronisers.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each SPI input synchroniser (≥2).
- HEADER, 4'hA, required value of byte0[7:4].
- TUNING_WIDTH, 32, width of the tuning-code field. Fixed at 32; the frame layout depends on it.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to i_clk, f_sclk ≤ f_clk/8.
- i_cs_n  in  1  SPI chip select, active-low, asynchronous.
- i_mosi  in  1  SPI data, MSB first, sampled on i_sclk rising edge.
- o_SPI_note_status  out  1  1 = note on, 0 = note off.
- o_SPI_voice_index  out  8  target voice.
- o_SPI_tuning_code  out  32  DDS phase increment.
- o_SPI_velocity  out  8  note velocity.
- o_SPI_flag  out  1  one-cycle strobe; all fields valid in the same cycle.
- o_frame_error  out  1  one-cycle strobe on a rejected frame.

Behaviour:
- Reset values: every output and all internal state = 0. The synchronisers reset with i_cs_n stages = 1 and other stages = 0.
- Reset asserted mid-frame: the partial frame is discarded and no flag or error is produced.
- Synchronisation and edge detection:
  - i_sclk, i_cs_n and i_mosi each pass through SYNC_STAGES flops.
  - Rising-edge detect on synchronised sclk.
  - Rising- and falling-edge detect on synchronised cs_n.
- Frame format, 56 bits, MSB first:
  - byte0: [7:4] = HEADER, [3:1] = don't care, [0] = note_status.
  - byte1: voice_index.
  - bytes2–5: tuning_code[31:0], MSB byte first.
  - byte6: velocity.
- FSM states:
  - IDLE:
    - Wait for the cs_n falling edge.
    - On that edge: clear the 56-bit shift register and the 6-bit bit counter, then go to SHIFT.
  - SHIFT:
    - On each synchronised sclk rising edge, shift in mosi. The bit counter increments and saturates at 63; it does not wrap.
    - On the cs_n rising edge, go to CHECK.
    - A cs_n rising edge and an sclk edge in the same cycle: the sclk edge is ignored.
  - CHECK (1 cycle):
    - Valid when bit count == 56 and byte0[7:4] == HEADER.
    - If valid: load all four output fields from the shift register and pulse o_SPI_flag.
    - Otherwise: leave the fields unchanged and pulse o_frame_error.
    - Return to IDLE.
- Output timing:
  - The flag or error is high for exactly one i_clk cycle, in the cycle after CHECK is entered.
  - Pin-to-strobe latency from the i_cs_n rise is SYNC_STAGES+2 cycles (±1 for synchroniser metastability).
- Field outputs hold their last valid values until the next valid frame. They change only in the same cycle as the o_SPI_flag pulse.
- Count-based rejections (frame_error, fields untouched):
  - Zero-length CS pulse (count 0).
  - Short frame (<56 bits).
  - Long frame (>56 bits, including ≥63 bits).
- A cs_n falling edge while in CHECK is ignored. The MCU must hold cs_n high ≥4 i_clk cycles between frames.
- sclk edges while cs_n is high are ignored.
- No MISO; the link is write-only.

Test Plan:
1. Reset held low 10 cycles, then released → all outputs 0; no flag, no error.
2. Frame A0 FD 01 31 2D 00 64 at f_clk/8 → single o_SPI_flag pulse with note_status=0, voice_index=253, tuning_code=20000000 (0x01312D00), velocity=100.
3. Frame A1 FC 01 31 2D 00 7F, then 4 idle cycles, then frame A0 FC 00 00 00 00 00 → two flags, back-to-back:
   - first: note_status=1, voice=252, velocity=127;
   - second: note_status=0, voice=252, tuning=0.
4. Frame with header B1 and otherwise valid bytes → o_frame_error pulse, no flag; fields retain the scenario-3 values.
5. 55-bit frame, then a 57-bit frame, then a zero-length CS pulse → three o_frame_error pulses, no flag, fields unchanged.
6. Reset asserted after 30 bits of a valid frame, released, then a full valid frame sent → no strobe for the aborted frame; the new frame decodes correctly with exactly one flag.
